// File: rtl/keypad_scan_rx_if.sv
// Keypad scanner signal bundle: scan strobe and row sense in, column drive and key events out.
// The slave modport is the scanner's view; the master modport is the environment's view.
interface keypad_scan_rx_if;
  logic       tick;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    output tick,
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_held
  );

  modport slave (
    input  tick,
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_held
  );
endinterface

// File: rtl/keypad_scan_rx.sv
// 4x4 matrix keypad scanner/debouncer, stepped only by the scan strobe.
// Optional auto-repeat of a held key is compiled in with `define KEYPAD_REPEAT_EN.
module keypad_scan_rx #(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int RELEASE_TICKS  = 2,
  parameter int REPEAT_DELAY   = 25,
  parameter int REPEAT_PERIOD  = 5
) (
  input logic              clk,
  input logic              rst,
  keypad_scan_rx_if.slave  kp
);

  if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 15 || RELEASE_TICKS < 1 || RELEASE_TICKS > 15 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_range
    $error("keypad_scan_rx: parameter out of range");
  end

  localparam logic [3:0] DB_T = 4'(DEBOUNCE_TICKS);
  localparam logic [3:0] RL_T = 4'(RELEASE_TICKS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [3:0] rot_left(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

  // Lowest set bit wins when several rows are pressed together.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous row inputs.
  logic [3:0] row_sync_p0, row_sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_sync_p0 <= 4'hF;
      row_sync_p1 <= 4'hF;
    end else begin
      row_sync_p0 <= kp.row_n;
      row_sync_p1 <= row_sync_p0;
    end
  end

  logic [3:0] rs;
  assign rs = ~row_sync_p1;

  state_t     state_q, state_d;
  logic [3:0] col_q, col_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       held_q, held_d;
  logic [3:0] pat_q;
  logic       latch;
  logic       accept;
  logic [3:0] cnt_inc, rcnt_inc;

  assign cnt_inc  = sat_inc4(cnt_q);
  assign rcnt_inc = sat_inc4(rcnt_q);

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_PER = REP_W'(REPEAT_PERIOD);

  function automatic logic [REP_W-1:0] sat_inc_rep(input logic [REP_W-1:0] v);
    return (v == {REP_W{1'b1}}) ? v : v + REP_W'(1);
  endfunction

  logic [REP_W-1:0] rep_q, rep_d, rep_inc;
  logic             rep_done_q, rep_done_d;

  assign rep_inc = sat_inc_rep(rep_q);
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    code_d  = code_q;
    held_d  = held_q;
    valid_d = 1'b0;
    latch   = 1'b0;
    accept  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d      = rep_q;
    rep_done_d = rep_done_q;
`endif
    if (kp.tick) begin
      case (state_q)
        SCAN: begin
          if (rs == 4'd0) begin
            col_d = rot_left(col_q);
          end else begin
            latch = 1'b1;
            cnt_d = 4'd1;
            if (DB_T == 4'd1) accept = 1'b1;
            else              state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (rs == 4'd0) begin
            // Column stays put so the same key is re-sampled on the next strobe.
            state_d = SCAN;
          end else if (rs == pat_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_T) accept = 1'b1;
          end else begin
            latch = 1'b1;
            cnt_d = 4'd1;
          end
        end
        HELD: begin
          if (rs == 4'd0) begin
            rcnt_d = rcnt_inc;
            if (rcnt_inc >= RL_T) begin
              held_d  = 1'b0;
              col_d   = rot_left(col_q);
              rcnt_d  = 4'd0;
              state_d = SCAN;
            end
`ifdef KEYPAD_REPEAT_EN
            rep_d      = '0;
            rep_done_d = 1'b0;
`endif
          end else begin
            rcnt_d = 4'd0;
`ifdef KEYPAD_REPEAT_EN
            if (!rep_done_q) begin
              if (rep_inc >= REP_DLY) begin
                valid_d    = 1'b1;
                rep_done_d = 1'b1;
                rep_d      = '0;
              end else begin
                rep_d = rep_inc;
              end
            end else if (rep_inc >= REP_PER) begin
              valid_d = 1'b1;
              rep_d   = '0;
            end else begin
              rep_d = rep_inc;
            end
`endif
          end
        end
        default: state_d = SCAN;
      endcase

      if (accept) begin
        code_d  = {low_idx(rs), low_idx(~col_q)};
        valid_d = 1'b1;
        held_d  = 1'b1;
        cnt_d   = 4'd0;
        rcnt_d  = 4'd0;
        state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
        rep_d      = '0;
        rep_done_d = 1'b0;
`endif
      end
    end
  end

  // Stage p2: control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCAN;
      col_q   <= 4'b1110;
      cnt_q   <= 4'd0;
      rcnt_q  <= 4'd0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q      <= '0;
      rep_done_q <= 1'b0;
    end else begin
      rep_q      <= rep_d;
      rep_done_q <= rep_done_d;
    end
  end
`endif

  // Latched row pattern is only read in DEBOUNCE, after it has been written.
  always_ff @(posedge clk) begin
    if (latch) pat_q <= rs;
  end

  assign kp.col_n     = col_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_rx.sv
// Scoreboard bench for keypad_scan_rx: a keypad model drives rows from the column drive,
// expected key codes are queued with stimulus and a monitor pops them on each key_valid.
module tb_keypad_scan_rx;
  logic clk = 1'b0;
  logic rst;
  keypad_scan_rx_if kp();

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;

  logic       press_en;
  logic [1:0] press_col;
  logic [3:0] press_rows;

  always #5 clk = ~clk;

  // Keypad model: pressed rows pull low only while their column is driven.
  always_comb begin
    kp.row_n = 4'hF;
    if (press_en && kp.col_n[press_col] == 1'b0) kp.row_n = ~press_rows;
  end

  keypad_scan_rx dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_tick();
    repeat (6) @(negedge clk);
    kp.tick = 1'b1;
    @(negedge clk);
    kp.tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && kp.key_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_key_valid: got code %0d with no event expected", kp.key_code);
      end else begin
        mon_exp = exp_q.pop_front();
        if (kp.key_code !== mon_exp) begin
          errors++;
          $display("FAIL key_code_event: got %0d expected %0d", kp.key_code, mon_exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_col;
    rst        = 1'b1;
    kp.tick    = 1'b0;
    press_en   = 1'b0;
    press_col  = 2'd0;
    press_rows = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_col_n", 8'(kp.col_n), 8'b1110);
    check("reset_key_valid", 8'(kp.key_valid), 8'd0);
    check("reset_key_held", 8'(kp.key_held), 8'd0);
    check("reset_key_code", 8'(kp.key_code), 8'd0);
    rst = 1'b0;

    // Idle scanning: column rotates left once per strobe.
    exp_col = 4'b1110;
    for (int i = 0; i < 8; i++) begin
      do_tick();
      exp_col = {exp_col[2:0], exp_col[3]};
      check("idle_col_rotate", 8'(kp.col_n), 8'(exp_col));
    end

    // Row 2 / column 1 press -> code 9.
    press_col = 2'd1; press_rows = 4'b0100; press_en = 1'b1;
    do_tick();
    check("press_col_reach", 8'(kp.col_n), 8'b1101);
    do_tick();
    check("debounce1_held", 8'(kp.key_held), 8'd0);
    do_tick();
    check("debounce2_held", 8'(kp.key_held), 8'd0);
    exp_q.push_back(4'd9);
    do_tick();
    check("accept_held", 8'(kp.key_held), 8'd1);
    check("accept_code", 8'(kp.key_code), 8'd9);
    check("accept_col_frozen", 8'(kp.col_n), 8'b1101);
    ticks(3);
    check("held_col_frozen", 8'(kp.col_n), 8'b1101);
    check("held_still", 8'(kp.key_held), 8'd1);

    // Short release is ignored; two idle strobes release.
    press_en = 1'b0; do_tick();
    check("release1_held", 8'(kp.key_held), 8'd1);
    press_en = 1'b1; do_tick();
    check("repress_held", 8'(kp.key_held), 8'd1);
    press_en = 1'b0; do_tick();
    check("release_again1", 8'(kp.key_held), 8'd1);
    do_tick();
    check("released_held", 8'(kp.key_held), 8'd0);
    check("released_col", 8'(kp.col_n), 8'b1011);
    check("released_code_kept", 8'(kp.key_code), 8'd9);

    // Bouncing press on column 2 row 2, then stable -> code 10.
    press_col = 2'd2; press_rows = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      press_en = (i % 2 == 0);
      do_tick();
    end
    check("bounce_col_held", 8'(kp.col_n), 8'b1011);
    check("bounce_no_held", 8'(kp.key_held), 8'd0);
    press_en = 1'b1;
    ticks(2);
    exp_q.push_back(4'd10);
    do_tick();
    check("bounce_accept_held", 8'(kp.key_held), 8'd1);
    check("bounce_accept_code", 8'(kp.key_code), 8'd10);
    press_en = 1'b0; ticks(2);
    check("bounce_release_col", 8'(kp.col_n), 8'b0111);

    // Rows 1 and 3 on column 3: row 1 wins -> code 7.
    press_col = 2'd3; press_rows = 4'b1010; press_en = 1'b1;
    ticks(2);
    exp_q.push_back(4'd7);
    do_tick();
    check("multi_row_code", 8'(kp.key_code), 8'd7);
    check("multi_row_held", 8'(kp.key_held), 8'd1);
    press_en = 1'b0; ticks(2);
    check("multi_release_col", 8'(kp.col_n), 8'b1110);

    // Reset in the middle of debouncing (cnt=2).
    press_col = 2'd0; press_rows = 4'b0001; press_en = 1'b1;
    ticks(2);
    press_en = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_col", 8'(kp.col_n), 8'b1110);
    check("midrst_held", 8'(kp.key_held), 8'd0);
    check("midrst_valid", 8'(kp.key_valid), 8'd0);
    check("midrst_code", 8'(kp.key_code), 8'd0);
    rst = 1'b0;
    ticks(4);
    check("postrst_col", 8'(kp.col_n), 8'b1110);

    // 40-strobe hold of row 3 / column 0 -> code 12; repeats only when enabled.
    press_col = 2'd0; press_rows = 4'b1000; press_en = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      if (t == 3) exp_q.push_back(4'd12);
`ifdef KEYPAD_REPEAT_EN
      if (t == 28 || t == 33 || t == 38) exp_q.push_back(4'd12);
`endif
      do_tick();
    end
    check("long_hold_held", 8'(kp.key_held), 8'd1);
    check("long_hold_code", 8'(kp.key_code), 8'd12);
    press_en = 1'b0; ticks(2);
    check("long_release_held", 8'(kp.key_held), 8'd0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
